buff_reg_readback: RTL and testbench
====================================

Name: buff_reg_readback

Overview:
- Read-back path for the LVDA buffer and mode registers toward the LVDC.
- On a decoded read request, snapshots the 26-bit buffer-register word (BRD) or the mode-register word (MODR5/MODR6).
- Serializes the snapshot onto the computer data-in line, one bit per bit-time strobe, starting at the next word-sync. An odd-parity bit is optionally appended.
- Sits beside the buffer/mode register load logic and is the reader for the values that logic writes.

Parameters:
- WORD_BITS, 26: data bits serialized per word.
- PARITY, 1: when 1, append one odd-parity bit after the data bits; when 0, no parity bit.
- SYNC_TIMEOUT, 40: bit-time strobes allowed in ARMED without WSYNC before the read aborts with an error.

Ports:
- SIM_CLK  input  1  system clock; all state changes on the rising edge.
- SIM_RST  input  1  synchronous, active-high reset.
- BTS  input  1  bit-time strobe, one SIM_CLK cycle wide per serial bit time.
- WSYNC  input  1  word-start marker; sampled only when BTS=1.
- RDREQ  input  1  read request pulse, already decoded (LTRV, address, INFOV qualified).
- RDSEL  input  1  0 = buffer word, 1 = mode word.
- RDCLR  input  1  clears RDERR.
- BRD  input  WORD_BITS  live buffer-register bits. Word position n (n=0 is sign) is on index WORD_BITS-1-n. Unpopulated positions are tied 0.
- MODR  input  2  MODR[0]=MODR5, MODR[1]=MODR6.
- DATIN  output  1  serial data to the LVDC.
- DATINV  output  1  DATIN holds a valid bit.
- RDBUSY  output  1  read in progress (any state other than IDLE).
- RDDONE  output  1  one-cycle pulse when a word plus parity has completed.
- RDERR  output  1  sticky error flag.

Behaviour:
- Reset (SIM_RST=1 at an edge, any state):
  - State goes to IDLE.
  - DATIN, DATINV, RDBUSY, RDDONE and RDERR all go to 0.
  - Snapshot register, bit counter and timeout counter clear to 0.
  - Reset mid-shift abandons the word; no RDDONE is issued.
- States: IDLE, ARMED, SHIFT, PAR, DONE. All outputs are registered.
- IDLE:
  - RDREQ=1 loads the snapshot in the same edge and moves to ARMED. RDBUSY=1 from the next cycle.
  - With RDSEL=1 the snapshot is all zeros except MODR5 at position 5 and MODR6 at position 6.
  - Input changes after the snapshot edge have no effect on the transmitted word.
- ARMED:
  - Counts only on BTS=1.
  - BTS & WSYNC: go to SHIFT, DATIN = position 0, DATINV=1, bitcnt=1.
  - BTS & !WSYNC: tocnt+1. When tocnt reaches SYNC_TIMEOUT, set RDERR=1 and return to IDLE with no RDDONE.
  - WSYNC without BTS is ignored.
- SHIFT:
  - Each BTS drives position bitcnt onto DATIN and increments bitcnt.
  - After position WORD_BITS-1 has been driven, the next BTS goes to PAR if PARITY=1.
  - If PARITY=0, that BTS instead goes straight to DONE: DATINV=0, DATIN=0.
- PAR:
  - On entry, DATIN = XNOR-reduce of the snapshot, so total ones across data plus parity is odd.
  - The next BTS moves to DONE with DATINV=0 and DATIN=0.
- DONE: RDDONE=1 for exactly one cycle, then IDLE. RDBUSY=0 from the IDLE cycle onward.
- DATIN and DATINV change only on BTS edges and are held between strobes.
- RDREQ in any state other than IDLE, DONE included: request ignored, RDERR set.
- RDERR priority: SIM_RST, then new error set, then RDCLR. RDCLR in the same cycle as a new error leaves RDERR=1.
- Consecutive reads: a request is accepted in the first IDLE cycle after DONE.
- Counter widths are sized for WORD_BITS and SYNC_TIMEOUT. Counters never wrap within an operation.

Test Plan:
- Buffer word, PARITY=1: BRD=26'h2AAAAAA, RDSEL=0, RDREQ, WSYNC on 3rd BTS.
  - Response: DATIN sequence 1,0,1,0,… (26 bits), then parity=0 (13 ones is already odd).
  - DATINV high for 27 BTS; RDDONE pulse once; RDBUSY falls the following cycle.
- Mode word: MODR=2'b11, RDSEL=1, BRD=all ones.
  - Response: only positions 5 and 6 are 1, parity=1, and BRD is ignored.
- Snapshot hold: BRD changes to 0 one cycle after RDREQ.
  - Response: the transmitted word still equals the pre-change value.
- Timeout: RDREQ with no WSYNC for 40 BTS.
  - Response: RDERR=1, return to IDLE, no RDDONE, DATINV stays 0.
  - Then RDCLR: RDERR=0.
- Collision: RDREQ during SHIFT bit 10.
  - Response: word completes unchanged and RDERR=1.
  - RDCLR asserted together with a second collision leaves RDERR=1.
- Reset mid-word: SIM_RST at bit 12.
  - Response: all outputs 0 next cycle, no RDDONE.
  - A fresh RDREQ afterwards transmits correctly from position 0.

Source files
------------

// File: rtl/buff_reg_readback.sv
// buff_reg_readback
//   Read-back path for the LVDA buffer and mode registers toward the LVDC.
//   A decoded read request snapshots either the buffer-register word (BRD)
//   or the mode word (MODR5/MODR6 at positions 5/6). The snapshot is then
//   shifted onto DATIN one bit per bit-time strobe, starting at the next
//   word-sync. When PARITY=1, an odd-parity bit follows the data bits.
//
// Ports
//   SIM_CLK  system clock, rising edge
//   SIM_RST  synchronous active-high reset
//   BTS      bit-time strobe (one cycle per serial bit time)
//   WSYNC    word-start marker, only meaningful with BTS
//   RDREQ    decoded read request pulse
//   RDSEL    0 = buffer word, 1 = mode word
//   RDCLR    clears RDERR
//   BRD      live buffer bits; word position n is on index WORD_BITS-1-n
//   MODR     MODR[0]=MODR5, MODR[1]=MODR6
//   DATIN    serial data to the LVDC
//   DATINV   DATIN holds a valid bit
//   RDBUSY   read in progress
//   RDDONE   one-cycle pulse at word completion
//   RDERR    sticky error (timeout or request while busy)
module buff_reg_readback #(
  parameter int unsigned WORD_BITS    = 26,
  parameter int unsigned PARITY       = 1,
  parameter int unsigned SYNC_TIMEOUT = 40
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 BTS,
  input  logic                 WSYNC,
  input  logic                 RDREQ,
  input  logic                 RDSEL,
  input  logic                 RDCLR,
  input  logic [WORD_BITS-1:0] BRD,
  input  logic [1:0]           MODR,
  output logic                 DATIN,
  output logic                 DATINV,
  output logic                 RDBUSY,
  output logic                 RDDONE,
  output logic                 RDERR
);

  localparam int unsigned BW     = $clog2(WORD_BITS + 1);
  localparam int unsigned TW     = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned M5_IDX = WORD_BITS - 1 - 5;
  localparam int unsigned M6_IDX = WORD_BITS - 1 - 6;

  typedef enum logic [2:0] {IDLE, ARMED, SHIFT, PAR, DONE} state_t;

  state_t               state, state_n;
  // The snapshot is held as a left-shifting register: the MSB is always the
  // next word position to transmit. Parity is captured from the unshifted
  // snapshot at load time.
  logic [WORD_BITS-1:0] snap, snap_n;
  logic                 par_bit, par_n;
  logic [BW-1:0]        bitcnt, bitcnt_n;
  logic [TW-1:0]        tocnt, tocnt_n;
  logic                 datin_n, datinv_n, busy_n, done_n, err_n;
  logic                 err_set;
  logic [WORD_BITS-1:0] load_word;

  always_comb begin
    load_word = '0;
    if (RDSEL) begin
      load_word[M5_IDX] = MODR[0];
      load_word[M6_IDX] = MODR[1];
    end else begin
      load_word = BRD;
    end
  end

  always_comb begin
    state_n  = state;
    snap_n   = snap;
    par_n    = par_bit;
    bitcnt_n = bitcnt;
    tocnt_n  = tocnt;
    datin_n  = DATIN;
    datinv_n = DATINV;
    err_set  = RDREQ && (state != IDLE);

    case (state)
      IDLE: begin
        if (RDREQ) begin
          snap_n   = load_word;
          par_n    = ~^load_word;
          bitcnt_n = '0;
          tocnt_n  = '0;
          state_n  = ARMED;
        end
      end
      ARMED: begin
        if (BTS) begin
          if (WSYNC) begin
            datin_n  = snap[WORD_BITS-1];
            snap_n   = {snap[WORD_BITS-2:0], 1'b0};
            datinv_n = 1'b1;
            bitcnt_n = BW'(1);
            state_n  = SHIFT;
          end else if (tocnt == TW'(SYNC_TIMEOUT - 1)) begin
            err_set = 1'b1;
            tocnt_n = '0;
            state_n = IDLE;
          end else begin
            tocnt_n = tocnt + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (BTS) begin
          if (bitcnt == BW'(WORD_BITS)) begin
            if (PARITY != 0) begin
              datin_n = par_bit;
              state_n = PAR;
            end else begin
              datin_n  = 1'b0;
              datinv_n = 1'b0;
              state_n  = DONE;
            end
          end else begin
            datin_n  = snap[WORD_BITS-1];
            snap_n   = {snap[WORD_BITS-2:0], 1'b0};
            bitcnt_n = bitcnt + 1'b1;
          end
        end
      end
      PAR: begin
        if (BTS) begin
          datin_n  = 1'b0;
          datinv_n = 1'b0;
          state_n  = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A new error outranks a simultaneous clear.
    if (err_set) begin
      err_n = 1'b1;
    end else if (RDCLR) begin
      err_n = 1'b0;
    end else begin
      err_n = RDERR;
    end

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state   <= IDLE;
      snap    <= '0;
      par_bit <= 1'b0;
      bitcnt  <= '0;
      tocnt   <= '0;
      DATIN   <= 1'b0;
      DATINV  <= 1'b0;
      RDBUSY  <= 1'b0;
      RDDONE  <= 1'b0;
      RDERR   <= 1'b0;
    end else begin
      state   <= state_n;
      snap    <= snap_n;
      par_bit <= par_n;
      bitcnt  <= bitcnt_n;
      tocnt   <= tocnt_n;
      DATIN   <= datin_n;
      DATINV  <= datinv_n;
      RDBUSY  <= busy_n;
      RDDONE  <= done_n;
      RDERR   <= err_n;
    end
  end

endmodule

// File: tb/tb_buff_reg_readback.sv
// Testbench for buff_reg_readback: directed read sequences, with the
// expected serial bits of each word pushed to a queue when the read is
// requested and popped as the DUT presents each valid bit.
module tb_buff_reg_readback;

  logic        SIM_CLK;
  logic        SIM_RST;
  logic        BTS;
  logic        WSYNC;
  logic        RDREQ;
  logic        RDSEL;
  logic        RDCLR;
  logic [25:0] BRD;
  logic [1:0]  MODR;
  logic        DATIN;
  logic        DATINV;
  logic        RDBUSY;
  logic        RDDONE;
  logic        RDERR;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int valid_cnt  = 0;
  logic exp_q[$];
  logic prev_datin, prev_datinv;

  buff_reg_readback #(
    .WORD_BITS(26),
    .PARITY(1),
    .SYNC_TIMEOUT(40)
  ) dut (
    .SIM_CLK(SIM_CLK),
    .SIM_RST(SIM_RST),
    .BTS(BTS),
    .WSYNC(WSYNC),
    .RDREQ(RDREQ),
    .RDSEL(RDSEL),
    .RDCLR(RDCLR),
    .BRD(BRD),
    .MODR(MODR),
    .DATIN(DATIN),
    .DATINV(DATINV),
    .RDBUSY(RDBUSY),
    .RDDONE(RDDONE),
    .RDERR(RDERR)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial stream: positions 0..25 (MSB first), then odd parity.
  task automatic push_word(input logic [25:0] w);
    logic [25:0] t;
    int ones;
    t = w;
    ones = 0;
    for (int n = 0; n < 26; n++) begin
      exp_q.push_back(t[25]);
      if (t[25]) ones++;
      t = t << 1;
    end
    exp_q.push_back((ones % 2) == 0);
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic bts, input logic wsync);
    logic b;
    BTS   = bts;
    WSYNC = wsync;
    @(posedge SIM_CLK);
    #1;
    if (!SIM_RST) begin
      if (bts && DATINV) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_bit", {31'd0, DATINV}, 32'd0);
        end else begin
          b = exp_q.pop_front();
          check("datin_bit", {31'd0, DATIN}, {31'd0, b});
        end
      end
      if (!bts) begin
        check("datin_hold", {30'd0, DATINV, DATIN}, {30'd0, prev_datinv, prev_datin});
      end
    end
    if (RDDONE) done_cnt++;
    prev_datin  = DATIN;
    prev_datinv = DATINV;
    BTS   = 1'b0;
    WSYNC = 1'b0;
  endtask

  task automatic strobe();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic sync_strobe();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
  endtask

  task automatic start_read(input logic [25:0] brd, input logic sel,
                            input logic [1:0] modr, input logic [25:0] exp_word);
    BRD   = brd;
    RDSEL = sel;
    MODR  = modr;
    RDREQ = 1'b1;
    valid_cnt = 0;
    push_word(exp_word);
    cyc(1'b0, 1'b0);
    RDREQ = 1'b0;
    check("busy_after_req", {31'd0, RDBUSY}, 32'd1);
  endtask

  // Strobes until RDDONE (bounded), then checks the completion handshake.
  task automatic finish_word();
    int n;
    n = 0;
    while (!RDDONE && n < 40) begin
      cyc(1'b1, 1'b0);
      n++;
      if (!RDDONE) cyc(1'b0, 1'b0);
    end
    check("done_pulse", {31'd0, RDDONE}, 32'd1);
    check("done_datinv", {30'd0, DATINV, DATIN}, 32'd0);
    check("done_busy", {31'd0, RDBUSY}, 32'd1);
    check("valid_bits", valid_cnt, 32'd27);
    cyc(1'b0, 1'b0);
    check("done_one_cycle", {31'd0, RDDONE}, 32'd0);
    check("busy_falls", {31'd0, RDBUSY}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    SIM_RST = 1'b1;
    BTS = 1'b0; WSYNC = 1'b0; RDREQ = 1'b0; RDSEL = 1'b0; RDCLR = 1'b0;
    BRD = '0; MODR = '0;
    prev_datin = 1'b0; prev_datinv = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("reset_outputs", {27'd0, DATIN, DATINV, RDBUSY, RDDONE, RDERR}, 32'd0);
    SIM_RST = 1'b0;
    cyc(1'b0, 1'b0);

    // Buffer word, WSYNC on the 3rd strobe.
    start_read(26'h2AAAAAA, 1'b0, 2'b00, 26'h2AAAAAA);
    strobe();
    strobe();
    check("armed_no_valid", {31'd0, DATINV}, 32'd0);
    sync_strobe();
    check("first_bit_valid", {31'd0, DATINV}, 32'd1);
    finish_word();

    // Mode word, requested in the first IDLE cycle after DONE; BRD ignored.
    start_read(26'h3FFFFFF, 1'b1, 2'b11, 26'h0180000);
    check("back_to_back_no_err", {31'd0, RDERR}, 32'd0);
    sync_strobe();
    finish_word();

    // Snapshot hold: BRD changes right after the request edge.
    start_read(26'h1234567, 1'b0, 2'b00, 26'h1234567);
    BRD = '0;
    strobe();
    sync_strobe();
    finish_word();

    // Timeout: 40 strobes without WSYNC.
    start_read(26'h3FFFFFF, 1'b0, 2'b00, 26'h0);
    exp_q.delete();
    for (int i = 0; i < 39; i++) strobe();
    check("timeout_minus1_busy", {30'd0, RDBUSY, RDERR}, 32'd2);
    cyc(1'b1, 1'b0);
    check("timeout_err", {31'd0, RDERR}, 32'd1);
    check("timeout_idle", {31'd0, RDBUSY}, 32'd0);
    check("timeout_no_done", {31'd0, RDDONE}, 32'd0);
    check("timeout_no_valid", valid_cnt, 32'd0);
    cyc(1'b0, 1'b0);
    RDCLR = 1'b1;
    cyc(1'b0, 1'b0);
    RDCLR = 1'b0;
    check("rdclr_clears", {31'd0, RDERR}, 32'd0);

    // Collision during SHIFT, then RDCLR together with a second collision.
    start_read(26'h3C0F0F1, 1'b0, 2'b00, 26'h3C0F0F1);
    sync_strobe();
    for (int i = 0; i < 10; i++) strobe();
    RDREQ = 1'b1;
    cyc(1'b0, 1'b0);
    RDREQ = 1'b0;
    check("collision_err", {31'd0, RDERR}, 32'd1);
    check("collision_busy", {31'd0, RDBUSY}, 32'd1);
    for (int i = 0; i < 5; i++) strobe();
    RDREQ = 1'b1;
    RDCLR = 1'b1;
    cyc(1'b0, 1'b0);
    RDREQ = 1'b0;
    RDCLR = 1'b0;
    check("set_beats_clear", {31'd0, RDERR}, 32'd1);
    finish_word();
    RDCLR = 1'b1;
    cyc(1'b0, 1'b0);
    RDCLR = 1'b0;
    check("rdclr_after_collision", {31'd0, RDERR}, 32'd0);

    // Reset at bit 12, then a fresh read from position 0.
    start_read(26'h155AA33, 1'b0, 2'b00, 26'h155AA33);
    sync_strobe();
    for (int i = 0; i < 12; i++) strobe();
    SIM_RST = 1'b1;
    cyc(1'b0, 1'b0);
    SIM_RST = 1'b0;
    check("midword_reset", {27'd0, DATIN, DATINV, RDBUSY, RDDONE, RDERR}, 32'd0);
    exp_q.delete();
    cyc(1'b0, 1'b0);
    check("reset_no_done", {31'd0, RDDONE}, 32'd0);
    start_read(26'h0F0F0F0, 1'b0, 2'b00, 26'h0F0F0F0);
    sync_strobe();
    finish_word();

    check("total_done_pulses", done_cnt, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
